// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: datapath widths, ALU opcodes and the ID->EX register layout.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_XOR = 3'b010,
    ALU_SLT = 3'b011,
    ALU_BLT = 3'b100,
    ALU_BGE = 3'b101,
    ALU_NOP = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       input_1;
    logic [XLEN-1:0]       input_2;
    alu_op_e               alu_cntrl;
    logic                  br_en;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [XLEN-1:0]       store_data;
    logic [XLEN-1:0]       pc;
  } id_ex_t;

  // A bubble must look inert to every downstream stage, including the ALU result.
  localparam id_ex_t ID_EX_BUBBLE = '{
    valid:      1'b0,
    input_1:    '0,
    input_2:    '0,
    alu_cntrl:  ALU_NOP,
    br_en:      1'b0,
    rd_addr:    '0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    store_data: '0,
    pc:         '0
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the decode-side, hazard/forwarding and EX-side signals around the ID->EX register.
interface id_ex_stage_if;
  import riscv_pkg::*;

  logic                  id_valid;
  logic                  id_ready;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic                  id_use_imm;
  logic [2:0]            id_alu_cntrl;
  logic                  id_br_en;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;

  logic [XLEN-1:0]       alu_result;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic                  mem_reg_write;
  logic [XLEN-1:0]       mem_data;
  logic                  br_taken;
  logic                  ex_hold;

  logic                  ex_valid;
  logic [XLEN-1:0]       ex_input_1;
  logic [XLEN-1:0]       ex_input_2;
  logic [2:0]            ex_alu_cntrl;
  logic                  ex_br_en;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic [XLEN-1:0]       ex_store_data;
  logic [XLEN-1:0]       ex_pc;

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_data, id_rs2_data, id_imm, id_use_imm, id_alu_cntrl,
           id_br_en, id_reg_write, id_mem_read, id_mem_write,
           alu_result, mem_rd_addr, mem_reg_write, mem_data, br_taken, ex_hold,
    input  id_ready, ex_valid, ex_input_1, ex_input_2, ex_alu_cntrl, ex_br_en,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, ex_pc
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_data, id_rs2_data, id_imm, id_use_imm, id_alu_cntrl,
           id_br_en, id_reg_write, id_mem_read, id_mem_write,
           alu_result, mem_rd_addr, mem_reg_write, mem_data, br_taken, ex_hold,
    output id_ready, ex_valid, ex_input_1, ex_input_2, ex_alu_cntrl, ex_br_en,
           ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, ex_pc
  );

endinterface

// File: rtl/fwd_mux.sv
// Operand bypass for one source register: x0 is hard zero, EX result beats MEM result beats regfile.
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [XLEN-1:0]       src_data,
  input  logic                  ex_fwd_en,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [XLEN-1:0]       ex_data,
  input  logic                  mem_fwd_en,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]       mem_data,
  output logic [XLEN-1:0]       fwd_data
);

  always_comb begin
    fwd_data = src_data;
    if (src_addr == '0) begin
      fwd_data = '0;
    end else if (ex_fwd_en && (ex_rd_addr == src_addr)) begin
      fwd_data = ex_data;
    end else if (mem_fwd_en && (mem_rd_addr == src_addr)) begin
      fwd_data = mem_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with operand forwarding, load-use bubbles and taken-branch flush.
module id_ex_stage
  import riscv_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  id_ex_t          ex_q;
  id_ex_t          ex_d;
  id_ex_t          id_cap;
  logic            uses_rs2;
  logic            load_use;
  logic            ex_fwd_en;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A load in EX has no data yet, so it can only be bypassed from MEM one cycle later.
  assign ex_fwd_en = ex_q.valid && ex_q.reg_write && !ex_q.mem_read;
  assign uses_rs2  = !bus.id_use_imm || bus.id_mem_write || bus.id_br_en;
  assign load_use  = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                     ((bus.id_rs1_addr == ex_q.rd_addr) ||
                      (uses_rs2 && (bus.id_rs2_addr == ex_q.rd_addr)));

  fwd_mux u_fwd_rs1 (
    .src_addr    (bus.id_rs1_addr),
    .src_data    (bus.id_rs1_data),
    .ex_fwd_en   (ex_fwd_en),
    .ex_rd_addr  (ex_q.rd_addr),
    .ex_data     (bus.alu_result),
    .mem_fwd_en  (bus.mem_reg_write),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_data    (bus.mem_data),
    .fwd_data    (fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .src_addr    (bus.id_rs2_addr),
    .src_data    (bus.id_rs2_data),
    .ex_fwd_en   (ex_fwd_en),
    .ex_rd_addr  (ex_q.rd_addr),
    .ex_data     (bus.alu_result),
    .mem_fwd_en  (bus.mem_reg_write),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_data    (bus.mem_data),
    .fwd_data    (fwd_rs2)
  );

  always_comb begin
    id_cap            = ID_EX_BUBBLE;
    id_cap.valid      = 1'b1;
    id_cap.input_1    = fwd_rs1;
    id_cap.input_2    = bus.id_use_imm ? bus.id_imm : fwd_rs2;
    id_cap.alu_cntrl  = alu_op_e'(bus.id_alu_cntrl);
    id_cap.br_en      = bus.id_br_en;
    id_cap.rd_addr    = bus.id_rd_addr;
    id_cap.reg_write  = bus.id_reg_write;
    id_cap.mem_read   = bus.id_mem_read;
    id_cap.mem_write  = bus.id_mem_write;
    id_cap.store_data = fwd_rs2;
    id_cap.pc         = bus.id_pc;
  end

  // Flush wins over the load-use bubble, which wins over a downstream hold.
  always_comb begin
    ex_d = ex_q;
    if (bus.br_taken || load_use) begin
      ex_d = ID_EX_BUBBLE;
    end else if (!bus.ex_hold) begin
      ex_d = bus.id_valid ? id_cap : ID_EX_BUBBLE;
    end
  end

  assign bus.id_ready = !rst && (bus.br_taken || (!load_use && !bus.ex_hold));

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= ID_EX_BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_input_1    = ex_q.input_1;
  assign bus.ex_input_2    = ex_q.input_2;
  assign bus.ex_alu_cntrl  = ex_q.alu_cntrl;
  assign bus.ex_br_en      = ex_q.br_en;
  assign bus.ex_rd_addr    = ex_q.rd_addr;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_store_data = ex_q.store_data;
  assign bus.ex_pc         = ex_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reset, a directed vector table, a load-use sequence and a random run vs. a model.
module tb_id_ex_stage;
  import riscv_pkg::*;

  typedef struct {
    logic        id_valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        use_imm;
    logic [2:0]  alu;
    logic        br_en, reg_write, mem_read, mem_write;
    logic [31:0] alu_result;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] mem_data;
    logic        br_taken, ex_hold;
    logic        exp_ready, exp_valid;
    logic [31:0] exp_in1, exp_in2, exp_store;
    logic [2:0]  exp_alu;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] in1, in2, store, pc;
    logic [2:0]  alu;
    logic        br_en, reg_write, mem_read, mem_write;
    logic [4:0]  rd;
  } model_t;

  localparam int NV = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs [NV];
  model_t mdl;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic vec_t makeInstr(input logic [4:0] rs1, input logic [31:0] rs1_data,
                                     input logic [4:0] rs2, input logic [31:0] rs2_data,
                                     input logic [4:0] rd, input logic [2:0] alu,
                                     input logic use_imm, input logic [31:0] imm,
                                     input logic reg_write, input logic mem_read);
    vec_t v;
    v = '{default: '0};
    v.id_valid  = 1'b1;
    v.rs1       = rs1;
    v.rs1_data  = rs1_data;
    v.rs2       = rs2;
    v.rs2_data  = rs2_data;
    v.rd        = rd;
    v.alu       = alu;
    v.use_imm   = use_imm;
    v.imm       = imm;
    v.reg_write = reg_write;
    v.mem_read  = mem_read;
    return v;
  endfunction

  function automatic vec_t withExpect(input vec_t vin, input logic ready, input logic valid,
                                      input logic [31:0] in1, input logic [31:0] in2,
                                      input logic [2:0] alu, input logic [31:0] store);
    vec_t v;
    v = vin;
    v.exp_ready = ready;
    v.exp_valid = valid;
    v.exp_in1   = in1;
    v.exp_in2   = in2;
    v.exp_alu   = alu;
    v.exp_store = store;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input logic [31:0] pc);
    bus.id_valid      = v.id_valid;
    bus.id_pc         = pc;
    bus.id_rs1_addr   = v.rs1;
    bus.id_rs2_addr   = v.rs2;
    bus.id_rd_addr    = v.rd;
    bus.id_rs1_data   = v.rs1_data;
    bus.id_rs2_data   = v.rs2_data;
    bus.id_imm        = v.imm;
    bus.id_use_imm    = v.use_imm;
    bus.id_alu_cntrl  = v.alu;
    bus.id_br_en      = v.br_en;
    bus.id_reg_write  = v.reg_write;
    bus.id_mem_read   = v.mem_read;
    bus.id_mem_write  = v.mem_write;
    bus.alu_result    = v.alu_result;
    bus.mem_rd_addr   = v.mem_rd;
    bus.mem_reg_write = v.mem_reg_write;
    bus.mem_data      = v.mem_data;
    bus.br_taken      = v.br_taken;
    bus.ex_hold       = v.ex_hold;
  endtask

  // Reference operand value: x0 reads zero, a non-load in EX is newest, then MEM, then the regfile.
  function automatic logic [31:0] refOperand(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 5'd0) return 32'd0;
    if (mdl.valid && mdl.reg_write && !mdl.mem_read && mdl.rd == addr) return bus.alu_result;
    if (bus.mem_reg_write && bus.mem_rd_addr == addr) return bus.mem_data;
    return rf;
  endfunction

  function automatic model_t bubbleModel();
    model_t m;
    m = '{default: '0};
    m.alu = 3'b110;
    return m;
  endfunction

  task automatic checkModel(input int cyc);
    checkOutput($sformatf("rnd%0d valid", cyc), 32'(bus.ex_valid), 32'(mdl.valid));
    checkOutput($sformatf("rnd%0d in1", cyc), bus.ex_input_1, mdl.in1);
    checkOutput($sformatf("rnd%0d in2", cyc), bus.ex_input_2, mdl.in2);
    checkOutput($sformatf("rnd%0d store", cyc), bus.ex_store_data, mdl.store);
    checkOutput($sformatf("rnd%0d pc", cyc), bus.ex_pc, mdl.pc);
    checkOutput($sformatf("rnd%0d ctrl", cyc),
                {20'd0, bus.ex_alu_cntrl, bus.ex_br_en, bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
                {20'd0, mdl.alu, mdl.br_en, mdl.rd, mdl.reg_write, mdl.mem_read, mdl.mem_write});
  endtask

  initial begin
    vec_t v;
    model_t nxt;
    logic exp_rdy, uses2, hazard;

    // Directed table; each row's expectation follows from the EX contents left by the row before.
    vecs[0] = withExpect(makeInstr(5'd1, 32'h1, 5'd2, 32'h2, 5'd5, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0),
                         1'b1, 1'b1, 32'h1, 32'h2, 3'b000, 32'h2);
    v = makeInstr(5'd5, 32'h99, 5'd3, 32'h3, 5'd5, 3'b001, 1'b0, 32'h0, 1'b1, 1'b0);
    v.alu_result = 32'h10;
    vecs[1] = withExpect(v, 1'b1, 1'b1, 32'h10, 32'h3, 3'b001, 32'h3);
    v = makeInstr(5'd5, 32'h77, 5'd0, 32'h123, 5'd7, 3'b010, 1'b0, 32'h0, 1'b1, 1'b0);
    v.alu_result = 32'h10; v.mem_rd = 5'd5; v.mem_reg_write = 1'b1; v.mem_data = 32'h20;
    vecs[2] = withExpect(v, 1'b1, 1'b1, 32'h10, 32'h0, 3'b010, 32'h0);
    v = makeInstr(5'd9, 32'h1, 5'd5, 32'h2, 5'd8, 3'b011, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0);
    v.alu_result = 32'h55; v.mem_rd = 5'd9; v.mem_reg_write = 1'b1; v.mem_data = 32'hAB;
    vecs[3] = withExpect(v, 1'b1, 1'b1, 32'hAB, 32'hFFFF_FFF0, 3'b011, 32'h2);
    vecs[4] = withExpect(makeInstr(5'd1, 32'h4, 5'd2, 32'h5, 5'd0, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0),
                         1'b1, 1'b1, 32'h4, 32'h5, 3'b000, 32'h5);
    v = makeInstr(5'd0, 32'h33, 5'd0, 32'h44, 5'd3, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0);
    v.alu_result = 32'h55; v.mem_rd = 5'd0; v.mem_reg_write = 1'b1; v.mem_data = 32'h66;
    vecs[5] = withExpect(v, 1'b1, 1'b1, 32'h0, 32'h0, 3'b000, 32'h0);
    vecs[6] = withExpect(makeInstr(5'd2, 32'h100, 5'd0, 32'h9, 5'd7, 3'b000, 1'b1, 32'h8, 1'b1, 1'b1),
                         1'b1, 1'b1, 32'h100, 32'h8, 3'b000, 32'h0);
    v = makeInstr(5'd7, 32'h1, 5'd1, 32'h2, 5'd4, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0);
    v.br_taken = 1'b1; v.ex_hold = 1'b1;
    vecs[7] = withExpect(v, 1'b1, 1'b0, 32'h0, 32'h0, 3'b110, 32'h0);
    v = '{default: '0};
    vecs[8] = withExpect(v, 1'b1, 1'b0, 32'h0, 32'h0, 3'b110, 32'h0);
    v = makeInstr(5'd3, 32'd10, 5'd4, 32'd20, 5'd0, 3'b100, 1'b0, 32'h0, 1'b0, 1'b0);
    v.br_en = 1'b1;
    vecs[9] = withExpect(v, 1'b1, 1'b1, 32'd10, 32'd20, 3'b100, 32'd20);
    v = makeInstr(5'd1, 32'h1, 5'd2, 32'h2, 5'd6, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0);
    v.ex_hold = 1'b1;
    vecs[10] = withExpect(v, 1'b0, 1'b1, 32'd10, 32'd20, 3'b100, 32'd20);

    // Reset with a valid instruction waiting: nothing may be consumed.
    v = makeInstr(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 3'b001, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(v, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("reset ready", 32'(bus.id_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ready late", 32'(bus.id_ready), 32'd0);
    checkOutput("reset valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("reset alu", 32'(bus.ex_alu_cntrl), 32'd6);
    checkOutput("reset in1", bus.ex_input_1, 32'd0);
    checkOutput("reset in2", bus.ex_input_2, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i], 32'h1000 + 32'(i) * 4);
      #1;
      checkOutput($sformatf("v%0d ready", i), 32'(bus.id_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d valid", i), 32'(bus.ex_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d in1", i), bus.ex_input_1, vecs[i].exp_in1);
      checkOutput($sformatf("v%0d in2", i), bus.ex_input_2, vecs[i].exp_in2);
      checkOutput($sformatf("v%0d alu", i), 32'(bus.ex_alu_cntrl), 32'(vecs[i].exp_alu));
      checkOutput($sformatf("v%0d store", i), bus.ex_store_data, vecs[i].exp_store);
    end

    // Load-use: LW x7 then ADD using x7 stalls once, then picks the load data up from MEM.
    applyStimulus(makeInstr(5'd1, 32'h200, 5'd0, 32'h0, 5'd7, 3'b000, 1'b1, 32'h4, 1'b1, 1'b1), 32'h2000);
    @(posedge clk);
    #1;
    checkOutput("lw mem_read", 32'(bus.ex_mem_read), 32'd1);
    v = makeInstr(5'd1, 32'h1, 5'd7, 32'h1111, 5'd8, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(v, 32'h2004);
    #1;
    checkOutput("lu ready", 32'(bus.id_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lu bubble valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("lu bubble alu", 32'(bus.ex_alu_cntrl), 32'd6);
    v.mem_rd = 5'd7; v.mem_reg_write = 1'b1; v.mem_data = 32'hDEAD_BEEF;
    applyStimulus(v, 32'h2004);
    #1;
    checkOutput("lu retry ready", 32'(bus.id_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("lu retry valid", 32'(bus.ex_valid), 32'd1);
    checkOutput("lu retry in2", bus.ex_input_2, 32'hDEAD_BEEF);
    checkOutput("lu retry pc", bus.ex_pc, 32'h2004);

    // Random run against the reference model, starting from a fresh reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl = bubbleModel();
    for (int c = 0; c < 400; c++) begin
      v = '{default: '0};
      v.id_valid      = ($urandom_range(0, 7) != 0);
      v.rs1           = 5'($urandom_range(0, 3));
      v.rs2           = 5'($urandom_range(0, 3));
      v.rd            = 5'($urandom_range(0, 3));
      v.rs1_data      = $urandom;
      v.rs2_data      = $urandom;
      v.imm           = $urandom;
      v.use_imm       = 1'($urandom);
      v.alu           = 3'($urandom_range(0, 5));
      v.br_en         = ($urandom_range(0, 5) == 0);
      v.reg_write     = 1'($urandom);
      v.mem_read      = ($urandom_range(0, 2) == 0);
      v.mem_write     = !v.mem_read && ($urandom_range(0, 4) == 0);
      v.alu_result    = $urandom;
      v.mem_rd        = 5'($urandom_range(0, 3));
      v.mem_reg_write = 1'($urandom);
      v.mem_data      = $urandom;
      v.br_taken      = ($urandom_range(0, 9) == 0);
      v.ex_hold       = ($urandom_range(0, 6) == 0);
      applyStimulus(v, $urandom);
      #1;
      uses2  = !v.use_imm || v.mem_write || v.br_en;
      hazard = v.id_valid && mdl.valid && mdl.mem_read && mdl.rd != 5'd0 &&
               (v.rs1 == mdl.rd || (uses2 && v.rs2 == mdl.rd));
      nxt = bubbleModel();
      if (v.br_taken) begin
        exp_rdy = 1'b1;
      end else if (hazard) begin
        exp_rdy = 1'b0;
      end else if (v.ex_hold) begin
        exp_rdy = 1'b0;
        nxt = mdl;
      end else begin
        exp_rdy = 1'b1;
        if (v.id_valid) begin
          nxt.valid     = 1'b1;
          nxt.in1       = refOperand(v.rs1, v.rs1_data);
          nxt.store     = refOperand(v.rs2, v.rs2_data);
          nxt.in2       = v.use_imm ? v.imm : nxt.store;
          nxt.pc        = bus.id_pc;
          nxt.alu       = v.alu;
          nxt.br_en     = v.br_en;
          nxt.rd        = v.rd;
          nxt.reg_write = v.reg_write;
          nxt.mem_read  = v.mem_read;
          nxt.mem_write = v.mem_write;
        end
      end
      checkOutput($sformatf("rnd%0d ready", c), 32'(bus.id_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      mdl = nxt;
      checkModel(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
